genesis_pad_responder: RTL and testbench

- Controller-side end of the Sega Genesis DB9 pad protocol. The existing controller interface in GuyBox drives select (pin6) and samples pin0..pin3, pin5 and pin8; this block answers that select line.
- It drives the six data pins from an 8-bit button vector plus four extended buttons, so a GuyBox can emulate a pad toward another console/board.
- Doubles as the reference responder in system benches.
- Supports the 3-button protocol and, optionally, the 6-button protocol, which counts select pulses and uses an idle timeout.

---
 rtl/genesis_pad_responder.sv | 130 +++++++++++++
 tb/tb_genesis_pad_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/genesis_pad_responder.sv
`default_nettype none
// ============================================================================
// Module      : genesis_pad_responder
// Description : Controller-side Sega Genesis DB9 pad responder. It answers the
//               host select line with the 3-button or 6-button protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module genesis_pad_responder #(
  parameter int SIX_BUTTON     = 1,
  parameter int TIMEOUT_CYCLES = 4688,
  parameter int TW             = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buttons,
  input  logic [3:0] buttons_ext,
  input  logic       sel,
  output logic       pin0,
  output logic       pin1,
  output logic       pin2,
  output logic       pin3,
  output logic       pin5,
  output logic       pin8,
  output logic [2:0] low_count
);

  typedef enum logic [2:0] {
    N_HIGH   = 3'd0,
    N_LOW    = 3'd1,
    Z_LOW    = 3'd2,
    EXT_HIGH = 3'd3,
    O_LOW    = 3'd4
  } pad_mode_e;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          sel_meta_q;
  logic          sel_s_q;
  logic          sel_d_q;
  logic [7:0]    btn_q;
  logic [3:0]    ext_q;
  logic [2:0]    cnt_q;
  logic [2:0]    cnt_d;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic [5:0]    pins_q;
  logic [5:0]    pins_d;
  logic          fe;
  logic          re;
  logic          expire;
  pad_mode_e     pad_mode;

  assign fe     = sel_d_q & ~sel_s_q;
  assign re     = ~sel_d_q & sel_s_q;
  assign expire = (tmo_q == TMO_LAST);

  // Expiry clears the count first, so a falling edge on that cycle lands on 1.
  always_comb begin
    tmo_d = tmo_q;
    cnt_d = cnt_q;
    if (fe || re) begin
      tmo_d = '0;
    end else if (!expire) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (expire) begin
      cnt_d = 3'd0;
    end
    if (fe && (cnt_d != 3'd4)) begin
      cnt_d = cnt_d + 3'd1;
    end
  end

  // The pins follow the updated count so the edge and its data change together.
  always_comb begin
    pad_mode = sel_s_q ? N_HIGH : N_LOW;
    if (SIX_BUTTON != 0) begin
      if (sel_s_q) begin
        if (cnt_d == 3'd3) pad_mode = EXT_HIGH;
      end else if (cnt_d == 3'd3) begin
        pad_mode = Z_LOW;
      end else if (cnt_d == 3'd4) begin
        pad_mode = O_LOW;
      end
    end

    // Bit order: {pin8, pin5, pin3, pin2, pin1, pin0}
    pins_d = 6'h3F;
    case (pad_mode)
      N_HIGH:   pins_d = {~btn_q[6], ~btn_q[5], ~btn_q[3], ~btn_q[2], ~btn_q[1], ~btn_q[0]};
      N_LOW:    pins_d = {~btn_q[7], ~btn_q[4], 2'b00, ~btn_q[1], ~btn_q[0]};
      Z_LOW:    pins_d = {~btn_q[7], ~btn_q[4], 4'b0000};
      EXT_HIGH: pins_d = {~btn_q[6], ~btn_q[5], ~ext_q[3], ~ext_q[0], ~ext_q[1], ~ext_q[2]};
      O_LOW:    pins_d = {~btn_q[7], ~btn_q[4], 4'b1111};
      default:  pins_d = 6'h3F;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_meta_q <= 1'b1;
      sel_s_q    <= 1'b1;
      sel_d_q    <= 1'b1;
      btn_q      <= 8'h00;
      ext_q      <= 4'h0;
      cnt_q      <= 3'd0;
      tmo_q      <= '0;
      pins_q     <= 6'h3F;
    end else begin
      sel_meta_q <= sel;
      sel_s_q    <= sel_meta_q;
      sel_d_q    <= sel_s_q;
      btn_q      <= buttons;
      ext_q      <= buttons_ext;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      pins_q     <= pins_d;
    end
  end

  assign pin0      = pins_q[0];
  assign pin1      = pins_q[1];
  assign pin2      = pins_q[2];
  assign pin3      = pins_q[3];
  assign pin5      = pins_q[4];
  assign pin8      = pins_q[5];
  assign low_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_genesis_pad_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_genesis_pad_responder
// Description : Bench for genesis_pad_responder, 6-button and 3-button builds
//               checked every cycle against a protocol-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_genesis_pad_responder;

  localparam int TO = 300;
  localparam int TWB = 9;

  logic       clk;
  logic       reset;
  logic [7:0] buttons;
  logic [3:0] buttons_ext;
  logic       sel;
  logic [5:0] pins6;
  logic [5:0] pins3;
  logic [2:0] lc6;
  logic [2:0] lc3;

  int n_cmp;
  int n_bad;
  bit chk_en;

  // Reference model state
  bit         hs[$];
  int         cnt;
  int         quiet;
  logic [7:0] m_btn;
  logic [3:0] m_ext;
  logic [5:0] exp6;
  logic [5:0] exp3;

  genesis_pad_responder #(.SIX_BUTTON(1), .TIMEOUT_CYCLES(TO), .TW(TWB)) u_dut6 (
    .clk(clk), .reset(reset), .buttons(buttons), .buttons_ext(buttons_ext), .sel(sel),
    .pin0(pins6[0]), .pin1(pins6[1]), .pin2(pins6[2]), .pin3(pins6[3]),
    .pin5(pins6[4]), .pin8(pins6[5]), .low_count(lc6)
  );

  genesis_pad_responder #(.SIX_BUTTON(0), .TIMEOUT_CYCLES(TO), .TW(TWB)) u_dut3 (
    .clk(clk), .reset(reset), .buttons(buttons), .buttons_ext(buttons_ext), .sel(sel),
    .pin0(pins3[0]), .pin1(pins3[1]), .pin2(pins3[2]), .pin3(pins3[3]),
    .pin5(pins3[4]), .pin8(pins3[5]), .low_count(lc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pin pattern {pin8, pin5, pin3, pin2, pin1, pin0} straight from the protocol table.
  function automatic logic [5:0] pad_map(input bit six, input bit s, input int c,
                                         input logic [7:0] b, input logic [3:0] x);
    if (s) begin
      if (six && c == 3) return {~b[6], ~b[5], ~x[3], ~x[0], ~x[1], ~x[2]};
      return {~b[6], ~b[5], ~b[3], ~b[2], ~b[1], ~b[0]};
    end
    if (six && c == 3) return {~b[7], ~b[4], 4'b0000};
    if (six && c == 4) return {~b[7], ~b[4], 4'b1111};
    return {~b[7], ~b[4], 2'b00, ~b[1], ~b[0]};
  endfunction

  task automatic m_reset();
    hs = '{1'b1, 1'b1, 1'b1};
    cnt = 0;
    quiet = 0;
    m_btn = 8'h00;
    m_ext = 4'h0;
    exp6 = 6'h3F;
    exp3 = 6'h3F;
  endtask

  // hs holds the select level seen at the last three clocks, oldest first;
  // the pads see select two clocks late, and edges compare it with one clock earlier.
  task automatic m_step();
    bit s;
    bit sp;
    bit fe;
    bit re;
    s  = hs[1];
    sp = hs[0];
    fe = sp & ~s;
    re = ~sp & s;
    quiet++;
    if (quiet >= TO) cnt = 0;
    if (fe && cnt < 4) cnt++;
    if (fe || re) quiet = 0;
    exp6 = pad_map(1'b1, s, cnt, m_btn, m_ext);
    exp3 = pad_map(1'b0, s, cnt, m_btn, m_ext);
    m_btn = buttons;
    m_ext = buttons_ext;
    hs.push_back(sel);
    void'(hs.pop_front());
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) m_reset();
    else        m_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pins6", {2'b00, pins6}, {2'b00, exp6});
      check("cnt6", {5'd0, lc6}, 8'(cnt));
      check("pins3", {2'b00, pins3}, {2'b00, exp3});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulses(input int n, input int ph);
    repeat (n) begin
      sel = 1'b0;
      cyc(ph);
      sel = 1'b1;
      cyc(ph);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    chk_en = 1'b0;
    reset = 1'b0;
    sel = 1'b1;
    buttons = 8'hFF;
    buttons_ext = 4'hF;
    m_reset();
    cyc(1);
    chk_en = 1'b1;

    // Reset held with select toggling
    repeat (6) begin
      sel = ~sel;
      cyc(1);
    end
    sel = 1'b1;
    cyc(3);
    reset = 1'b1;
    cyc(2);
    check("rel_pins", {2'b00, pins6}, 8'h00);

    // Basic mapping, both builds
    buttons = 8'b1001_0001;
    cyc(5);
    check("map_hi", {2'b00, pins3}, {2'b00, 6'b111110});
    sel = 1'b0;
    cyc(3);
    check("map_lo", {2'b00, pins3}, {2'b00, 6'b000010});
    sel = 1'b1;
    cyc(TO + 5);

    // Full 6-button frame plus saturation
    buttons = 8'h00;
    buttons_ext = 4'b0101;
    pulses(5, 20);
    check("sat", {5'd0, lc6}, 8'd4);

    // Timeout after three pulses, then a fresh count
    cyc(TO + 5);
    pulses(3, 20);
    cyc(TO + 5);
    check("tmo_cnt", {5'd0, lc6}, 8'd0);
    sel = 1'b0;
    cyc(5);
    check("after_tmo", {5'd0, lc6}, 8'd1);
    sel = 1'b1;
    cyc(TO + 5);

    // Falling edge exactly on the expiry cycle
    pulses(2, 20);
    sel = 1'b0;
    cyc(20);
    sel = 1'b1;
    cyc(TO);
    sel = 1'b0;
    cyc(5);
    check("edge_win", {5'd0, lc6}, 8'd1);
    sel = 1'b1;
    cyc(TO + 5);

    // Asynchronous reset during EXT_HIGH
    buttons_ext = 4'b1010;
    pulses(2, 20);
    sel = 1'b0;
    cyc(20);
    sel = 1'b1;
    cyc(10);
    check("ext_cnt", {5'd0, lc6}, 8'd3);
    reset = 1'b0;
    #1;
    check("arst_pins", {2'b00, pins6}, 8'h3F);
    check("arst_cnt", {5'd0, lc6}, 8'd0);
    cyc(1);
    reset = 1'b1;
    pulses(4, 10);
    cyc(TO + 5);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      buttons = 8'($urandom);
      buttons_ext = 4'($urandom);
      sel = ~sel;
      case ($urandom_range(0, 19))
        0: cyc(TO - 2 + int'($urandom_range(0, 4)));
        1: begin
          reset = 1'b0;
          cyc(1 + int'($urandom_range(0, 1)));
          reset = 1'b1;
          cyc(int'($urandom_range(1, 5)));
        end
        default: cyc(int'($urandom_range(1, 25)));
      endcase
    end
    cyc(5);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
